// File: rtl/inst_fetcher.sv
// Instruction fetcher: assembles a 32-bit little-endian instruction one byte
// at a time. Each byte is looked up in the cache first. On a miss the byte is
// read over the memory bus and written back into the cache.
module inst_fetcher #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc_i,
  input  logic        req_i,
  input  logic        flush_i,
  output logic [31:0] cache_raddr_o,
  input  logic        cache_hit_i,
  input  logic [7:0]  cache_data_i,
  output logic        cache_we_o,
  output logic [31:0] cache_waddr_o,
  output logic [7:0]  cache_wdata_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, LOOKUP, MEMRD, DONE} state_t;

  // Wait counter compares against the latency; 1..3 fits in two bits.
  localparam logic [1:0] LAT = 2'(MEM_LAT);

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic            granted_q, granted_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [3:0][7:0] buf_q, buf_d;
  logic [31:0]     inst_q, inst_d;
  logic [31:0]     inst_pc_q, inst_pc_d;
  logic [31:0]     byte_addr;

  // Address of the byte currently being fetched (wraps modulo 2^32).
  assign byte_addr = fetch_pc_q + {30'd0, cnt_q};

  // State registers; reset clears everything, otherwise take the next values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      granted_q  <= 1'b0;
      fetch_pc_q <= '0;
      buf_q      <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      granted_q  <= granted_d;
      fetch_pc_q <= fetch_pc_d;
      buf_q      <= buf_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  // Next-state and output logic; rdy low leaves every _d equal to its _q.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wcnt_d        = wcnt_q;
    granted_d     = granted_q;
    fetch_pc_d    = fetch_pc_q;
    buf_d         = buf_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    cache_raddr_o = '0;
    cache_we_o    = 1'b0;
    cache_waddr_o = '0;
    cache_wdata_o = '0;
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    inst_valid_o  = 1'b0;
    busy_o        = (state_q != IDLE);
    // The DONE cycle presents the fresh buffer; other cycles hold the last result.
    inst_o        = (state_q == DONE) ? buf_q : inst_q;
    inst_pc_o     = (state_q == DONE) ? fetch_pc_q : inst_pc_q;

    if (state_q == LOOKUP) cache_raddr_o = byte_addr;

    if (rdy) begin
      if (flush_i) begin
        // Redirect: drop the fetch, including any outstanding bus read.
        state_d   = IDLE;
        cnt_d     = '0;
        wcnt_d    = '0;
        granted_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_i) begin
              fetch_pc_d = pc_i;
              cnt_d      = '0;
              state_d    = LOOKUP;
            end
          end
          LOOKUP: begin
            if (cache_hit_i) begin
              buf_d[cnt_q] = cache_data_i;
              if (cnt_q == 2'd3) state_d = DONE;
              else               cnt_d   = cnt_q + 2'd1;
            end else begin
              granted_d = 1'b0;
              wcnt_d    = '0;
              state_d   = MEMRD;
            end
          end
          MEMRD: begin
            if (!granted_q) begin
              mem_req_o = 1'b1;
              if (mem_gnt_i) begin
                mem_addr_o = byte_addr;
                granted_d  = 1'b1;
                wcnt_d     = 2'd1;
              end
            end else if (wcnt_q == LAT) begin
              // Capture cycle: fill the cache and the buffer lane together.
              cache_we_o    = 1'b1;
              cache_waddr_o = byte_addr;
              cache_wdata_o = mem_data_i;
              buf_d[cnt_q]  = mem_data_i;
              granted_d     = 1'b0;
              wcnt_d        = '0;
              if (cnt_q == 2'd3) begin
                state_d = DONE;
              end else begin
                cnt_d   = cnt_q + 2'd1;
                state_d = LOOKUP;
              end
            end else begin
              wcnt_d = wcnt_q + 2'd1;
            end
          end
          DONE: begin
            inst_valid_o = 1'b1;
            inst_d       = buf_q;
            inst_pc_d    = fetch_pc_q;
            state_d      = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (rst) begin
      cache_raddr_o = '0;
      cache_we_o    = 1'b0;
      cache_waddr_o = '0;
      cache_wdata_o = '0;
      mem_req_o     = 1'b0;
      mem_addr_o    = '0;
      inst_valid_o  = 1'b0;
      busy_o        = 1'b0;
      inst_o        = '0;
      inst_pc_o     = '0;
    end
  end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning cycles from address issue (grant cycle) to mem_data_i valid; legal range 1..3.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port rdy  in  1  global enable; low freezes all state.
REQ-005 SHALL have ports pc_i  in  32  fetch address, and req_i  in  1  fetch request, sampled in IDLE only.
REQ-006 SHALL have port flush_i  in  1  abort current fetch (branch/jump redirect).
REQ-007 SHALL have ports cache_raddr_o  out  32  byte read address, cache_hit_i  in  1, and cache_data_i  in  8  combinational cache response.
REQ-008 SHALL have ports cache_we_o  out  1, cache_waddr_o  out  32, and cache_wdata_o  out  8  cache fill write.
REQ-009 SHALL have ports mem_req_o  out  1  bus request, mem_gnt_i  in  1  bus grant, mem_addr_o  out  32  byte address, and mem_data_i  in  8  read data.
REQ-010 SHALL have ports inst_o  out  32  assembled instruction, inst_pc_o  out  32  its address, inst_valid_o  out  1  one-cycle pulse, and busy_o  out  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, LOOKUP, MEMRD, DONE, with byte counter cnt (2 bits), latched fetch_pc (32 bits), and 4-byte buffer b0..b3.
REQ-012 In IDLE with req_i=1 and flush_i=0, the block SHALL latch fetch_pc=pc_i, set cnt=0, and go to LOOKUP.
REQ-013 In LOOKUP, cache_raddr_o SHALL equal fetch_pc+cnt (modulo 2^32, wrap permitted); in all other states it SHALL be 0.
REQ-014 In LOOKUP with cache_hit_i=1, the block SHALL store cache_data_i into byte lane cnt, then go to DONE if cnt=3, else increment cnt and stay in LOOKUP; one byte per cycle.
REQ-015 In LOOKUP with cache_hit_i=0, the block SHALL go to MEMRD.
REQ-016 In MEMRD, mem_req_o SHALL stay high until the grant cycle; in the grant cycle (mem_gnt_i=1), mem_addr_o SHALL equal fetch_pc+cnt; otherwise mem_addr_o SHALL be 0.
REQ-017 After grant, mem_req_o SHALL drop and a wait counter SHALL count MEM_LAT cycles; mem_data_i SHALL be captured in the cycle exactly MEM_LAT cycles after the grant cycle.
REQ-018 In the capture cycle, cache_we_o SHALL be 1 with cache_waddr_o=fetch_pc+cnt and cache_wdata_o=mem_data_i; the byte SHALL be stored in lane cnt; the next state SHALL be DONE if cnt=3, else LOOKUP with cnt+1.
REQ-019 cache_we_o SHALL be 0 in every cycle other than a capture cycle.
REQ-020 In DONE, the block SHALL output inst_valid_o=1, inst_o={b3,b2,b1,b0} (little-endian), and inst_pc_o=fetch_pc for one cycle, then go to IDLE; req_i SHALL NOT be accepted in DONE.
REQ-021 All-hit latency: with req accepted in cycle k, inst_valid_o SHALL be high in cycle k+5.
REQ-022 Outside DONE, inst_valid_o SHALL be 0; inst_o and inst_pc_o SHALL hold their last DONE values.
REQ-023 flush_i=1 in any state SHALL force IDLE at the next edge, and in that cycle SHALL suppress inst_valid_o, cache_we_o, and mem_req_o; flush SHALL win over a simultaneous req_i.
REQ-024 A memory read outstanding at flush SHALL be discarded: no cache write and no buffer update.
REQ-025 rdy=0 SHALL hold all registers; cache_we_o, mem_req_o, and inst_valid_o SHALL be forced to 0 while rdy=0; operation SHALL resume unchanged when rdy returns to 1.

Reset
REQ-026 rst=1 at a clock edge SHALL set state=IDLE and clear cnt, the wait counter, fetch_pc, b0..b3, inst_o, and inst_pc_o to 0.
REQ-027 While rst=1, all outputs SHALL be 0; rst SHALL override flush_i, rdy, and req_i.
REQ-028 Reset asserted mid-fetch SHALL abandon the fetch with no cache write and no inst_valid_o.

Verification
REQ-029 Reset: hold rst 2 cycles, then idle -> all outputs 0, busy_o=0.
REQ-030 All hit: cache holds 0x13,0x05,0x00,0x00 at 0x100..0x103; req at cycle k -> inst_valid_o at k+5, inst_o=0x00000513, inst_pc_o=0x100, no mem_req_o.
REQ-031 Full miss, MEM_LAT=1, immediate grant, memory bytes 0x93,0x00,0x10,0x00 at 0x200 -> mem_addr_o 0x200..0x203 in order, four cache_we_o pulses with matching addr/data, inst_o=0x00100093.
REQ-032 Miss with grant delayed 3 cycles -> mem_req_o high for 4 cycles, mem_addr_o valid only in the grant cycle, completion delayed exactly 3 cycles versus immediate grant.
REQ-033 Flush in the cycle after grant -> no cache_we_o, no inst_valid_o, IDLE next cycle; a following req at 0x300 fetches correctly.
REQ-034 rdy low for 2 cycles during LOOKUP at cnt=1 -> same inst_o, inst_valid_o 2 cycles later, no spurious writes.
